// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg
// Shared definitions for the command frame engine: FSM state encoding,
// command/response byte values, NAK error codes and state-class helpers.
package cmd_frame_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_COUNT,
        S_PAYLOAD,
        S_CHK,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_TX,
        S_RD_CHK,
        S_RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    localparam logic [7:0] ERR_CMD        = 8'h01;
    localparam logic [7:0] ERR_COUNT      = 8'h02;
    localparam logic [7:0] ERR_CHK        = 8'h03;
    localparam logic [7:0] ERR_TIMEOUT    = 8'h04;
    localparam logic [7:0] ERR_RD_TIMEOUT = 8'h05;

    // States that are receiving a frame: inter-byte timeout applies here.
    function automatic logic is_rx_state(input state_t s);
        return s inside {S_CMD, S_ADDR, S_COUNT, S_PAYLOAD, S_CHK};
    endfunction

    // States in which an incoming byte cannot be used and is discarded.
    function automatic logic is_drop_state(input state_t s);
        return s inside {S_WRITE, S_RD_REQ, S_RD_WAIT, S_RD_TX, S_RD_CHK, S_RESP};
    endfunction

endpackage

// File: rtl/cmd_payload_buffer.sv
// cmd_payload_buffer
// Write-payload store: written one byte at a time through byte-lane enables,
// read one whole register at a time (combinational read).
// Ports:
//   clk      clock
//   wr_idx   register slot being filled
//   wr_be    one-hot byte-lane enable (all zero = no write)
//   wr_byte  byte written into the enabled lane
//   rd_idx   register slot being read
//   rd_data  full register value at rd_idx
module cmd_payload_buffer
    import cmd_frame_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int REG_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = 2
) (
    input  logic                            clk,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [REG_WIDTH-1:0]            wr_be,
    input  logic [WORD_WIDTH-1:0]           wr_byte,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic [REG_WIDTH*WORD_WIDTH-1:0] rd_data
);

    logic [REG_WIDTH*WORD_WIDTH-1:0] mem [DEPTH];

    // Contents carry no reset: every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < REG_WIDTH; l++) begin
            if (wr_be[l]) begin
                mem[wr_idx][l*WORD_WIDTH +: WORD_WIDTH] <= wr_byte;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cmd_frame_engine.sv
// cmd_frame_engine
// Parses SYNC/CMD/ADDR/N/payload/CHK frames from a byte stream, buffers write
// payload until the checksum verifies, then issues burst register writes or
// reads (auto-incrementing address) and streams ACK/NAK responses and read
// data to the TX FIFO under backpressure.
// Ports:
//   clk, i_reset_n            clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid      received byte strobe (no backpressure)
//   o_tx_data/o_tx_valid      response byte, held until i_tx_ready
//   i_tx_ready                TX FIFO can accept
//   o_w_en/o_w_addr/o_w_value register write strobe
//   o_r_en/o_r_addr           register read strobe
//   i_r_value/i_r_valid       read return data
//   o_busy                    engine not idle
//   o_err_count               saturating count of NAKs sent plus dropped bytes
module cmd_frame_engine
    import cmd_frame_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 8,
    parameter int                    REG_WIDTH     = 4,
    parameter int                    ADDR_WORDS    = 1,
    parameter int                    MAX_BURST     = 4,
    parameter logic [WORD_WIDTH-1:0] SYNC          = 8'hA5,
    parameter int                    TIMEOUT       = 100000,
    parameter int                    LITTLE_ENDIAN = 0
) (
    input  logic                             clk,
    input  logic                             i_reset_n,
    input  logic [WORD_WIDTH-1:0]            i_rx_data,
    input  logic                             i_rx_valid,
    output logic [WORD_WIDTH-1:0]            o_tx_data,
    output logic                             o_tx_valid,
    input  logic                             i_tx_ready,
    output logic                             o_w_en,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0] o_w_addr,
    output logic [REG_WIDTH*WORD_WIDTH-1:0]  o_w_value,
    output logic                             o_r_en,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0] o_r_addr,
    input  logic [REG_WIDTH*WORD_WIDTH-1:0]  i_r_value,
    input  logic                             i_r_valid,
    output logic                             o_busy,
    output logic [7:0]                       o_err_count
);

    localparam int AW    = ADDR_WORDS * WORD_WIDTH;
    localparam int RW    = REG_WIDTH * WORD_WIDTH;
    localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   n_q, n_d;
    logic [WORD_WIDTH-1:0]   beat_q, beat_d;
    logic [WORD_WIDTH-1:0]   bidx_q, bidx_d;
    logic [WORD_WIDTH-1:0]   chk_q, chk_d;
    logic                    is_rd_q, is_rd_d;
    logic                    nak_q, nak_d;
    logic [7:0]              code_q, code_d;
    logic [RW-1:0]           rdata_q, rdata_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [7:0]              err_q, err_d;

    logic [REG_WIDTH-1:0]    buf_we;
    logic [RW-1:0]           buf_rd;
    logic                    tx_valid, w_en, r_en, drop, nak_sent, tmo_hit;
    logic [WORD_WIDTH-1:0]   tx_data;
    logic [8:0]              err_sum;

    // Byte k of a register (in stream order) lives in this lane.
    function automatic int lane_of(input logic [WORD_WIDTH-1:0] k);
        return (LITTLE_ENDIAN != 0) ? int'(k) : REG_WIDTH - 1 - int'(k);
    endfunction

    cmd_payload_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .DEPTH      (MAX_BURST),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_idx  (beat_q[IDX_W-1:0]),
        .wr_be   (buf_we),
        .wr_byte (i_rx_data),
        .rd_idx  (beat_q[IDX_W-1:0]),
        .rd_data (buf_rd)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        n_d      = n_q;
        beat_d   = beat_q;
        bidx_d   = bidx_q;
        chk_d    = chk_q;
        is_rd_d  = is_rd_q;
        nak_d    = nak_q;
        code_d   = code_q;
        rdata_d  = rdata_q;
        tmo_d    = '0;
        buf_we   = '0;
        tx_valid = 1'b0;
        tx_data  = '0;
        w_en     = 1'b0;
        r_en     = 1'b0;
        nak_sent = 1'b0;
        drop     = i_rx_valid && is_drop_state(state_q);
        tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

        // A byte arriving on the expiry cycle wins and restarts the count.
        if (is_rx_state(state_q)) begin
            tmo_d = i_rx_valid ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == SYNC) begin
                    state_d = S_CMD;
                    nak_d   = 1'b0;
                end
            end
            S_CMD: begin
                if (i_rx_valid) begin
                    chk_d  = i_rx_data;
                    bidx_d = '0;
                    addr_d = '0;
                    if (i_rx_data == WORD_WIDTH'(CMD_WRITE)) begin
                        is_rd_d = 1'b0;
                        state_d = S_ADDR;
                    end else if (i_rx_data == WORD_WIDTH'(CMD_READ)) begin
                        is_rd_d = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_RESP;
                        nak_d   = 1'b1;
                        code_d  = ERR_CMD;
                    end
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    chk_d  = chk_q ^ i_rx_data;
                    addr_d = (addr_q << WORD_WIDTH) | AW'(i_rx_data);
                    if (bidx_q == WORD_WIDTH'(ADDR_WORDS - 1)) begin
                        bidx_d  = '0;
                        state_d = S_COUNT;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            S_COUNT: begin
                if (i_rx_valid) begin
                    chk_d  = chk_q ^ i_rx_data;
                    n_d    = i_rx_data;
                    beat_d = '0;
                    bidx_d = '0;
                    if (i_rx_data == '0 || i_rx_data > WORD_WIDTH'(MAX_BURST)) begin
                        state_d = S_RESP;
                        nak_d   = 1'b1;
                        code_d  = ERR_COUNT;
                    end else begin
                        state_d = is_rd_q ? S_CHK : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_valid) begin
                    chk_d                  = chk_q ^ i_rx_data;
                    buf_we[lane_of(bidx_q)] = 1'b1;
                    if (bidx_q == WORD_WIDTH'(REG_WIDTH - 1)) begin
                        bidx_d = '0;
                        if (beat_q == n_q - 1'b1) begin
                            beat_d  = '0;
                            state_d = S_CHK;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (i_rx_valid) begin
                    bidx_d = '0;
                    beat_d = '0;
                    if (i_rx_data != chk_q) begin
                        state_d = S_RESP;
                        nak_d   = 1'b1;
                        code_d  = ERR_CHK;
                    end else if (is_rd_q) begin
                        // Checksum register is reused to accumulate read data.
                        chk_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_en   = 1'b1;
                addr_d = addr_q + 1'b1;
                if (beat_q == n_q - 1'b1) begin
                    state_d = S_RESP;
                    bidx_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                r_en    = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (i_r_valid) begin
                    rdata_d = i_r_value;
                    bidx_d  = '0;
                    state_d = S_RD_TX;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                    nak_d   = 1'b1;
                    code_d  = ERR_RD_TIMEOUT;
                    bidx_d  = '0;
                end
            end
            S_RD_TX: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[lane_of(bidx_q)*WORD_WIDTH +: WORD_WIDTH];
                if (i_tx_ready) begin
                    chk_d = chk_q ^ tx_data;
                    if (bidx_q == WORD_WIDTH'(REG_WIDTH - 1)) begin
                        bidx_d = '0;
                        addr_d = addr_q + 1'b1;
                        if (beat_q == n_q - 1'b1) begin
                            state_d = S_RD_CHK;
                        end else begin
                            beat_d  = beat_q + 1'b1;
                            state_d = S_RD_REQ;
                        end
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            S_RD_CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
                if (i_tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                // bidx selects the response byte: 0 = ACK/NAK, 1 = error code.
                tx_valid = 1'b1;
                if (bidx_q == '0) begin
                    tx_data = nak_q ? WORD_WIDTH'(NAK) : WORD_WIDTH'(ACK);
                end else begin
                    tx_data = WORD_WIDTH'(code_q);
                end
                if (i_tx_ready) begin
                    if (bidx_q == '0 && nak_q) begin
                        nak_sent = 1'b1;
                        bidx_d   = bidx_q + 1'b1;
                    end else if (bidx_q == '0 && is_rd_q) begin
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (is_rx_state(state_q) && !i_rx_valid && tmo_hit) begin
            state_d = S_RESP;
            nak_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            bidx_d  = '0;
        end

        err_sum = {1'b0, err_q} + {8'd0, drop} + {8'd0, nak_sent};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            beat_q  <= '0;
            bidx_q  <= '0;
            chk_q   <= '0;
            is_rd_q <= 1'b0;
            nak_q   <= 1'b0;
            code_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            bidx_q  <= bidx_d;
            chk_q   <= chk_d;
            is_rd_q <= is_rd_d;
            nak_q   <= nak_d;
            code_q  <= code_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from the state register, so reset clears them at once.
    assign o_tx_valid  = tx_valid;
    assign o_tx_data   = tx_data;
    assign o_w_en      = w_en;
    assign o_w_addr    = w_en ? addr_q : '0;
    assign o_w_value   = w_en ? buf_rd : '0;
    assign o_r_en      = r_en;
    assign o_r_addr    = r_en ? addr_q : '0;
    assign o_busy      = (state_q != S_IDLE);
    assign o_err_count = err_q;

endmodule

// File: tb/tb_cmd_frame_engine.sv
// tb_cmd_frame_engine
// Directed frames with hand-computed responses; expected TX bytes, writes and
// read addresses are queued by the stimulus and popped by a monitor.
module tb_cmd_frame_engine;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_w_en;
    logic [7:0]  o_w_addr;
    logic [31:0] o_w_value;
    logic        o_r_en;
    logic [7:0]  o_r_addr;
    logic [31:0] i_r_value = '0;
    logic        i_r_valid = 1'b0;
    logic        o_busy;
    logic [7:0]  o_err_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        withhold_r = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  e_tx;
    logic [39:0] e_wr;
    logic [7:0]  e_rd;
    logic [7:0]  r_addr_seen;
    bytes_t      fr;

    always #5 clk = ~clk;

    cmd_frame_engine #(.TIMEOUT(60)) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_w_en      (o_w_en),
        .o_w_addr    (o_w_addr),
        .o_w_value   (o_w_value),
        .o_r_en      (o_r_en),
        .o_r_addr    (o_r_addr),
        .i_r_value   (i_r_value),
        .i_r_valid   (i_r_valid),
        .o_busy      (o_busy),
        .o_err_count (o_err_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bytes_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic expect_tx(input bytes_t e);
        foreach (e[i]) tx_q.push_back(e[i]);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0 || o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_complete"}, 32'(n < budget), 32'd1);
        tx_q.delete();
        wr_q.delete();
        rd_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Fixed register contents returned for reads.
    function automatic logic [31:0] rd_model(input logic [7:0] a);
        case (a)
            8'hFE:   return 32'hDEADBEEF;
            8'hFF:   return 32'h01234567;
            8'h00:   return 32'h89ABCDEF;
            default: return 32'h00000000;
        endcase
    endfunction

    // Monitor: compares every transferred byte, write and read strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (i_reset_n) begin
                if (prev_valid && !prev_ready) begin
                    chk("tx_hold_valid", 32'(o_tx_valid), 32'd1);
                    chk("tx_hold_data", 32'(o_tx_data), 32'(prev_data));
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (tx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected: got %h expected no byte", o_tx_data);
                    end else begin
                        e_tx = tx_q.pop_front();
                        chk("tx_byte", 32'(o_tx_data), 32'(e_tx));
                    end
                end
                if (o_w_en) begin
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got addr %h value %h expected no write", o_w_addr, o_w_value);
                    end else begin
                        e_wr = wr_q.pop_front();
                        chk("w_addr", 32'(o_w_addr), 32'(e_wr[39:32]));
                        chk("w_value", o_w_value, e_wr[31:0]);
                    end
                end
                if (o_r_en) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: got addr %h expected no read", o_r_addr);
                    end else begin
                        e_rd = rd_q.pop_front();
                        chk("r_addr", 32'(o_r_addr), 32'(e_rd));
                    end
                end
            end
            prev_valid = o_tx_valid && i_reset_n;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    // Register-bus read responder: answers two cycles into RD_WAIT.
    initial begin
        forever begin
            @(negedge clk);
            if (o_r_en && !withhold_r) begin
                r_addr_seen = o_r_addr;
                repeat (2) @(posedge clk);
                #1;
                i_r_value = rd_model(r_addr_seen);
                i_r_valid = 1'b1;
                @(posedge clk); #1;
                i_r_valid = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        checks++; errors++;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_w_en", 32'(o_w_en), 32'd0);
        chk("rst_err", 32'(o_err_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 i_reset_n = 1'b1;

        // Write N=2 at 0F, checksum D2
        wr_q.push_back({8'h0F, 32'h11223344});
        wr_q.push_back({8'h10, 32'h55667788});
        expect_tx('{8'h06});
        fr = '{8'hA5, 8'h57, 8'h0F, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'hD2};
        send_frame(fr);
        @(negedge clk);
        chk("wr_lat_first_en", 32'(o_w_en), 32'd1);
        chk("wr_lat_first_addr", 32'(o_w_addr), 32'h0F);
        @(negedge clk);
        chk("wr_lat_last_en", 32'(o_w_en), 32'd1);
        @(negedge clk);
        chk("wr_ack_lat_valid", 32'(o_tx_valid), 32'd1);
        chk("wr_ack_lat_data", 32'(o_tx_data), 32'h06);
        wait_idle("write", 200);
        chk("err_after_write", 32'(o_err_count), 32'd0);

        // Read N=3 at FE with wrap, backpressure and a stray byte
        rd_q.push_back(8'hFE);
        rd_q.push_back(8'hFF);
        rd_q.push_back(8'h00);
        expect_tx('{8'h06, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
                    8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h22});
        fr = '{8'hA5, 8'h52, 8'hFE, 8'h03, 8'hAF};
        send_frame(fr);
        @(negedge clk);
        chk("rd_ack_lat_valid", 32'(o_tx_valid), 32'd1);
        chk("rd_ack_lat_data", 32'(o_tx_data), 32'h06);
        @(negedge clk);
        chk("rd_ren_lat", 32'(o_r_en), 32'd1);
        repeat (5) @(posedge clk);
        #1 i_tx_ready = 1'b0;
        repeat (24) @(posedge clk);
        send_byte(8'hA5);
        repeat (24) @(posedge clk);
        #1 i_tx_ready = 1'b1;
        wait_idle("read", 400);
        chk("err_after_drop", 32'(o_err_count), 32'd1);

        // Bad checksum on a write frame
        expect_tx('{8'h15, 8'h03});
        fr = '{8'hA5, 8'h57, 8'h0F, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_frame(fr);
        wait_idle("bad_chk", 200);
        chk("err_after_bad_chk", 32'(o_err_count), 32'd2);

        // N = 0
        expect_tx('{8'h15, 8'h02});
        fr = '{8'hA5, 8'h57, 8'h0F, 8'h00};
        send_frame(fr);
        wait_idle("n_zero", 200);
        chk("err_after_n0", 32'(o_err_count), 32'd3);

        // Unknown command
        expect_tx('{8'h15, 8'h01});
        fr = '{8'hA5, 8'h41};
        send_frame(fr);
        wait_idle("bad_cmd", 200);
        chk("err_after_cmd", 32'(o_err_count), 32'd4);

        // Garbage before SYNC, then a good write N=1 at 20, checksum 46
        wr_q.push_back({8'h20, 32'hCAFEBABE});
        expect_tx('{8'h06});
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h57, 8'h20, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h46};
        send_frame(fr);
        wait_idle("garbage", 200);
        chk("err_after_garbage", 32'(o_err_count), 32'd4);

        // Inter-byte timeout in ADDR
        expect_tx('{8'h15, 8'h04});
        fr = '{8'hA5, 8'h57};
        send_frame(fr);
        wait_idle("rx_timeout", 300);
        chk("err_after_rx_tmo", 32'(o_err_count), 32'd5);

        // Read-response timeout, checksum 63
        withhold_r = 1'b1;
        rd_q.push_back(8'h30);
        expect_tx('{8'h06, 8'h15, 8'h05});
        fr = '{8'hA5, 8'h52, 8'h30, 8'h01, 8'h63};
        send_frame(fr);
        wait_idle("rd_timeout", 300);
        chk("err_after_rd_tmo", 32'(o_err_count), 32'd6);
        withhold_r = 1'b0;

        // Reset during PAYLOAD
        fr = '{8'hA5, 8'h57, 8'h40, 8'h01, 8'h11, 8'h22};
        send_frame(fr);
        #2 i_reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("mid_rst_w_en", 32'(o_w_en), 32'd0);
        chk("mid_rst_err", 32'(o_err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 i_reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 32'(o_busy), 32'd0);

        // Fresh frame after reset: write N=1 at 41, checksum 13
        wr_q.push_back({8'h41, 32'h01020304});
        expect_tx('{8'h06});
        fr = '{8'hA5, 8'h57, 8'h41, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h13};
        send_frame(fr);
        wait_idle("post_rst_write", 200);
        chk("err_after_fresh", 32'(o_err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
